row_col_dec: RTL and testbench
==============================

# row_col_dec

Thermometer-to-binary decoder for one 16×16 DCO capacitor bank, the inverse of the bank's row/column coder. It sits on the r_all/row/col bus between the coder and the DCO. It recovers the 8-bit tuning word actually applied to the bank, flags illegal codes, counts them, and reports when the applied word has been stable long enough for frequency measurement. It is used by the ADPLL monitor logic and by benches as a self-check on the bank control.

## Interface
Parameters:
- SETTLE_CYCLES, 4: consecutive identical legal words required before `settled` asserts (1..255).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  pipeline advance enable; low freezes all state.
- r_all  in  16  row-all-on thermometer; bit i set means row i is fully on.
- row  in  16  one-hot partial-row select.
- col  in  16  column thermometer for the partial row.
- clr_err  in  1  synchronous clear of `err_cnt` and `code_err`.
- word  out  8  decoded tuning word; holds the last legal value.
- word_vld  out  1  `word` updated from a legal code this cycle.
- code_err  out  1  sticky flag: an illegal code was seen.
- err_cnt  out  ERR_CNT_W  saturating count of illegal codes.
- settled  out  1  word stable for SETTLE_CYCLES legal samples.

## Operation
- Stage 1 (S1): when en=1, register r_all/row/col into s1_* and set s1_vld=1. When en=0, S1 holds and s1_vld=0.
- Stage 2 (S2): combinational decode of s1_*, registered into the outputs when en=1 and s1_vld=1.
- Definitions: R = popcount(s1_r_all), C = popcount(s1_col).
- Legal code requires all of the following:
  - s1_r_all is a contiguous run of ones from bit 0 (including all zero), with R ≤ 15.
  - s1_row is one-hot with its set bit at index R.
  - s1_col is a nonzero contiguous run of ones from bit 0.
- Decoded value: word = 16·R + C − 1, an 8-bit result that never overflows for legal codes.
  - Examples: r_all=0, row=0x0001, col=0x0001 gives 0.
  - r_all=0x7FFF, row=0x8000, col=0xFFFF gives 255.
  - r_all=0x0001, row=0x0002, col=0x0FFF gives 27.
- Legal sample: word takes the new value and word_vld=1 for one cycle.
- Illegal sample:
  - word holds and word_vld=0.
  - code_err is set.
  - err_cnt increments, saturating at 2^ERR_CNT_W − 1.
  - settled clears and stab_cnt is reset to 0.
- Settle tracking:
  - stab_cnt (8 bit) resets to 1 on a legal word that differs from the held word.
  - It increments, saturating at SETTLE_CYCLES, on a legal word equal to the held word.
  - settled = (stab_cnt == SETTLE_CYCLES), registered.
  - The first legal word after reset counts as "differs".
- clr_err=1 clears code_err and err_cnt next edge, independent of en.
  - If clr_err coincides with an illegal S2 sample, the result is code_err=1 and err_cnt=1.

## Timing
- Reset (rst_n=0 at an edge): every output is 0 on the following cycle: word=0, word_vld=0, code_err=0, err_cnt=0, settled=0. s1_vld, s1_* and stab_cnt are also 0.
- Latency: input at edge k produces word/word_vld at edge k+2, with en held high.
- Throughput: one decode per cycle, no backpressure.
- Settle timing: with a constant legal input and en=1, settled rises SETTLE_CYCLES−1 cycles after the first word_vld of that value.
- en=0 for any span:
  - No state changes except clr_err handling.
  - word_vld=0; settled and word hold.
  - On re-enable, the first S2 sample is the value captured at re-enable (S1 refreshes first).
- rst_n=0 mid-operation discards both pipeline stages; no partial sample is emitted after reset release.
- rst_n has priority over clr_err and en.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with arbitrary inputs → all outputs 0. Release with a legal input for word 28 → word_vld at the 2nd edge after release, word=28.
- Boundaries: apply words 0, 15, 16, 127, 255 in encoder format on consecutive cycles → word sequence 0, 15, 16, 127, 255, each with word_vld, 2-cycle latency, err_cnt=0.
- Settle: hold word 127 with SETTLE_CYCLES=4 → settled=1 on the 4th word_vld. Step to word 50 → settled=0 the next output cycle, then re-asserts after 4 samples.
- Illegal codes, each applied for one cycle: row=0x0003; row one-hot at index ≠ R; r_all=0x0005; col=0; r_all=0xFFFF. Expected: each gives word held, word_vld=0, code_err=1, err_cnt = 1..5.
- Saturation and clear:
  - ERR_CNT_W=2 with 5 illegal samples → err_cnt=3.
  - clr_err alone → err_cnt=0, code_err=0.
  - clr_err together with an illegal sample → err_cnt=1.
- en gating: deassert en for 10 cycles while changing inputs → outputs frozen, word_vld=0. Re-enable → word of the current input 2 cycles later.

Source files
------------

// File: rtl/row_col_dec.sv
`default_nettype none
// ============================================================================
// Module   : row_col_dec
// Purpose  : Thermometer-to-binary decoder for a 16x16 DCO capacitor bank.
//            Recovers the 8-bit tuning word from the r_all/row/col bus, flags
//            and counts illegal codes, and reports when the applied word has
//            been stable for SETTLE_CYCLES legal samples.
// Ports    : clk, rst_n (sync, active low), en (pipeline advance),
//            r_all/row/col (bank control bus), clr_err (error clear),
//            word/word_vld (decoded word), code_err (sticky illegal flag),
//            err_cnt (saturating illegal count), settled (stability flag)
// Revision : 1.0 - initial release
// ============================================================================
module row_col_dec #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [15:0]          r_all,
    input  logic [15:0]          row,
    input  logic [15:0]          col,
    input  logic                 clr_err,
    output logic [7:0]           word,
    output logic                 word_vld,
    output logic                 code_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 settled
);

    localparam logic [7:0]           SETTLE  = 8'(SETTLE_CYCLES);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

    // Stage 1 registers
    logic [15:0] s1_r_all;
    logic [15:0] s1_row;
    logic [15:0] s1_col;
    logic        s1_vld;

    // Stage 2 decode
    logic [4:0]  r_pop;
    logic [4:0]  c_pop;
    logic [4:0]  c_pop_m1;
    logic        r_ok;
    logic        row_ok;
    logic        col_ok;
    logic        legal;
    logic [7:0]  dec;
    logic [7:0]  stab_cnt;
    logic [7:0]  stab_nxt;
    logic        sample;

    always_comb begin
        r_pop = 5'd0;
        c_pop = 5'd0;
        for (int i = 0; i < 16; i++) begin
            r_pop = r_pop + {4'd0, s1_r_all[i]};
            c_pop = c_pop + {4'd0, s1_col[i]};
        end
        // x & (x+1) == 0 holds exactly for runs of ones starting at bit 0
        // (including zero); the all-ones case wraps and is excluded via R.
        r_ok     = ((s1_r_all & (s1_r_all + 16'd1)) == 16'd0) && (r_pop != 5'd16);
        row_ok   = (s1_row == (16'd1 << r_pop[3:0]));
        col_ok   = (s1_col != 16'd0) && ((s1_col & (s1_col + 16'd1)) == 16'd0);
        legal    = r_ok && row_ok && col_ok;
        c_pop_m1 = c_pop - 5'd1;
        // 16*R + C - 1 with R <= 15 and 1 <= C <= 16 is a plain concatenation
        dec      = {r_pop[3:0], c_pop_m1[3:0]};
    end

    // A fresh value (including the first after reset, since word=0 only
    // matches with stab_cnt=0 which increments to 1 anyway) restarts at 1.
    always_comb begin
        stab_nxt = stab_cnt;
        if (dec != word) begin
            stab_nxt = 8'd1;
        end else if (stab_cnt < SETTLE) begin
            stab_nxt = stab_cnt + 8'd1;
        end
    end

    assign sample = en && s1_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r_all <= 16'd0;
            s1_row   <= 16'd0;
            s1_col   <= 16'd0;
            s1_vld   <= 1'b0;
            word     <= 8'd0;
            word_vld <= 1'b0;
            code_err <= 1'b0;
            err_cnt  <= '0;
            settled  <= 1'b0;
            stab_cnt <= 8'd0;
        end else begin
            if (en) begin
                s1_r_all <= r_all;
                s1_row   <= row;
                s1_col   <= col;
                s1_vld   <= 1'b1;
            end else begin
                s1_vld   <= 1'b0;
            end

            word_vld <= 1'b0;
            if (sample) begin
                if (legal) begin
                    word     <= dec;
                    word_vld <= 1'b1;
                    stab_cnt <= stab_nxt;
                    settled  <= (stab_nxt == SETTLE);
                end else begin
                    stab_cnt <= 8'd0;
                    settled  <= 1'b0;
                end
            end

            // A clear coinciding with an illegal sample leaves that one error
            if (sample && !legal) begin
                code_err <= 1'b1;
                if (clr_err) begin
                    err_cnt <= ERR_ONE;
                end else if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + ERR_ONE;
                end
            end else if (clr_err) begin
                code_err <= 1'b0;
                err_cnt  <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_row_col_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_col_dec
// Purpose  : Self-checking scoreboard bench for row_col_dec. Each stimulus
//            cycle pushes its hand-computed expected output; a monitor pops
//            and compares when that output is due (two edges later).
//            A second instance with ERR_CNT_W=2 checks counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_row_col_dec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] r_all, row, col;
    logic        clr_err;
    logic [7:0]  word, word2;
    logic        word_vld, word_vld2;
    logic        code_err, code_err2;
    logic [7:0]  err_cnt;
    logic [1:0]  err_cnt2;
    logic        settled, settled2;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    logic clr_pending = 1'b0;

    typedef struct {
        int         due;
        logic       vld;
        logic [7:0] word;
        logic       ce;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        logic       set;
    } exp_t;

    exp_t q[$];

    row_col_dec #(.SETTLE_CYCLES(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .r_all(r_all), .row(row), .col(col),
        .clr_err(clr_err), .word(word), .word_vld(word_vld), .code_err(code_err),
        .err_cnt(err_cnt), .settled(settled)
    );

    row_col_dec #(.SETTLE_CYCLES(4), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .r_all(r_all), .row(row), .col(col),
        .clr_err(clr_err), .word(word2), .word_vld(word_vld2), .code_err(code_err2),
        .err_cnt(err_cnt2), .settled(settled2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endfunction

    // Drive one raw sample. clr marks a clear landing on the same edge that
    // produces this sample's output, so it is driven on the following cycle.
    task automatic step(input logic e, input logic [15:0] ra, input logic [15:0] rw,
                        input logic [15:0] cl, input logic clr,
                        input logic vld, input int w, input logic ce,
                        input int n, input int n2, input logic st);
        exp_t x;
        @(negedge clk);
        rst_n   = 1'b1;
        en      = e;
        r_all   = ra;
        row     = rw;
        col     = cl;
        clr_err = clr_pending;
        clr_pending = clr;
        x.due = cyc + 2; x.vld = vld; x.word = 8'(w); x.ce = ce;
        x.cnt = 8'(n); x.cnt2 = 2'(n2); x.set = st;
        q.push_back(x);
    endtask

    // Encoder-format sample for tuning word w
    task automatic stepw(input logic e, input int w, input logic clr,
                         input logic vld, input int ew, input logic ce,
                         input int n, input int n2, input logic st);
        int r, c;
        r = w / 16;
        c = (w % 16) + 1;
        step(e, 16'((32'h1 << r) - 1), 16'(32'h1 << r), 16'((32'h1 << c) - 1),
             clr, vld, ew, ce, n, n2, st);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            exp_t x;
            x = q.pop_front();
            chk("word_vld", int'(word_vld), int'(x.vld));
            chk("word",     int'(word),     int'(x.word));
            chk("code_err", int'(code_err), int'(x.ce));
            chk("err_cnt",  int'(err_cnt),  int'(x.cnt));
            chk("err_cnt_w2", int'(err_cnt2), int'(x.cnt2));
            chk("settled",  int'(settled),  int'(x.set));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; clr_err = 1'b0;
        r_all = 16'hA5A5; row = 16'h0F0F; col = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_word",     int'(word),     0);
        chk("rst_word_vld", int'(word_vld), 0);
        chk("rst_code_err", int'(code_err), 0);
        chk("rst_err_cnt",  int'(err_cnt),  0);
        chk("rst_settled",  int'(settled),  0);

        //    en  w   clr vld word ce  n  n2 set
        stepw(1, 28,  0,  1,  28,  0,  0, 0, 0);
        // boundary words
        stepw(1, 0,   0,  1,  0,   0,  0, 0, 0);
        stepw(1, 15,  0,  1,  15,  0,  0, 0, 0);
        stepw(1, 16,  0,  1,  16,  0,  0, 0, 0);
        stepw(1, 127, 0,  1,  127, 0,  0, 0, 0);
        stepw(1, 255, 0,  1,  255, 0,  0, 0, 0);
        // settle on 127, then step to 50
        stepw(1, 127, 0,  1,  127, 0,  0, 0, 0);
        stepw(1, 127, 0,  1,  127, 0,  0, 0, 0);
        stepw(1, 127, 0,  1,  127, 0,  0, 0, 0);
        stepw(1, 127, 0,  1,  127, 0,  0, 0, 1);
        stepw(1, 50,  0,  1,  50,  0,  0, 0, 0);
        stepw(1, 50,  0,  1,  50,  0,  0, 0, 0);
        stepw(1, 50,  0,  1,  50,  0,  0, 0, 0);
        stepw(1, 50,  0,  1,  50,  0,  0, 0, 1);
        // illegal codes: two-hot row, row at wrong index, gapped r_all, zero col, r_all full
        step(1, 16'h0000, 16'h0003, 16'h0001, 0, 0, 50, 1, 1, 1, 0);
        step(1, 16'h0001, 16'h0001, 16'h0001, 0, 0, 50, 1, 2, 2, 0);
        step(1, 16'h0005, 16'h0004, 16'h0001, 0, 0, 50, 1, 3, 3, 0);
        step(1, 16'h0000, 16'h0001, 16'h0000, 0, 0, 50, 1, 4, 3, 0);
        step(1, 16'hFFFF, 16'h0000, 16'h0001, 0, 0, 50, 1, 5, 3, 0);
        // same word after illegal restarts stability
        stepw(1, 50,  0,  1,  50,  1,  5, 3, 0);
        // clear with a legal sample, clear with an illegal sample, plain legal
        stepw(1, 50,  1,  1,  50,  0,  0, 0, 0);
        step(1, 16'h0000, 16'h0001, 16'h0000, 1, 0, 50, 1, 1, 1, 0);
        stepw(1, 50,  0,  1,  50,  1,  1, 1, 0);
        stepw(1, 50,  1,  1,  50,  0,  0, 0, 0);
        // this sample is stranded by en dropping before its decode edge
        stepw(1, 50,  0,  0,  50,  0,  0, 0, 0);
        for (int i = 0; i < 10; i++)
            stepw(0, 90 + i, 0, 0, 50, 0, 0, 0, 0);
        // re-enable on a new value and let it settle, then move off
        stepw(1, 200, 0,  1,  200, 0,  0, 0, 0);
        stepw(1, 200, 0,  1,  200, 0,  0, 0, 0);
        stepw(1, 200, 0,  1,  200, 0,  0, 0, 0);
        stepw(1, 200, 0,  1,  200, 0,  0, 0, 1);
        stepw(1, 200, 0,  1,  200, 0,  0, 0, 1);
        stepw(1, 201, 0,  1,  201, 0,  0, 0, 0);

        // flush: keep en high so the last samples reach the output
        repeat (4) begin
            @(negedge clk);
            en = 1'b1;
            clr_err = clr_pending;
            clr_pending = 1'b0;
        end
        total_cnt++;
        if (q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
